// File: rtl/spi_master_pkg.sv
// ============================================================================
// Package : spi_master_pkg
// Brief   : Lane-mode and FSM encodings plus lane helpers for the SPI TX path.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

  typedef enum logic [1:0] {
    LANE_SINGLE = 2'b00,
    LANE_DUAL   = 2'b01,
    LANE_QUAD   = 2'b10,
    LANE_RSVD   = 2'b11
  } lane_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_TRANSMIT = 2'b01,
    ST_STALL    = 2'b10
  } spi_state_e;

  // Reserved encoding collapses onto single-lane behaviour everywhere.
  function automatic logic [2:0] lane_count(input lane_mode_e mode);
    case (mode)
      LANE_DUAL: lane_count = 3'd2;
      LANE_QUAD: lane_count = 3'd4;
      default:   lane_count = 3'd1;
    endcase
  endfunction

  function automatic logic [1:0] lane_shift(input lane_mode_e mode);
    case (mode)
      LANE_DUAL: lane_shift = 2'd1;
      LANE_QUAD: lane_shift = 2'd2;
      default:   lane_shift = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_oe(input lane_mode_e mode);
    case (mode)
      LANE_DUAL: lane_oe = 4'b0011;
      LANE_QUAD: lane_oe = 4'b1111;
      default:   lane_oe = 4'b0001;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_lane_mux.sv
// ============================================================================
// Module : spi_tx_lane_mux
// Brief  : Maps the TX shift register onto the sdo lanes for the latched mode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx_lane_mux
  import spi_master_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] shift_reg,
  input  lane_mode_e        mode,
  input  logic              lsb_first,
  input  logic              active,
  output logic [3:0]        sdo,
  output logic [3:0]        sdo_oe
);

  // MSB-first takes the top bits with the higher lane most significant;
  // LSB-first takes the bottom bits with lane0 least significant.
  always_comb begin
    sdo    = 4'b0000;
    sdo_oe = 4'b0000;
    if (active) begin
      sdo_oe = lane_oe(mode);
      case (mode)
        LANE_DUAL: sdo[1:0] = lsb_first ? shift_reg[1:0] : shift_reg[WORD_W-1 -: 2];
        LANE_QUAD: sdo      = lsb_first ? shift_reg[3:0] : shift_reg[WORD_W-1 -: 4];
        default:   sdo[0]   = lsb_first ? shift_reg[0]   : shift_reg[WORD_W-1];
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_tx_ml.sv
// ============================================================================
// Module : spi_master_tx_ml
// Brief  : Multi-lane (1/2/4) SPI master transmit engine with word streaming.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_tx_ml
  import spi_master_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tx_edge,
  input  logic [1:0]        mode_in,
  input  logic              lsb_first_in,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [WORD_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        sdo,
  output logic [3:0]        sdo_oe,
  output logic              tx_done,
  output logic              clk_en_o,
  output logic              underrun
);

  localparam int C_WB_W = $clog2(WORD_W);

  spi_state_e         r_state;
  spi_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_bit_len;
  lane_mode_e         r_mode;
  logic               r_lsb;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_beat;
  logic [C_WB_W-1:0]  r_wbeat;
  logic [WORD_W-1:0]  r_shift;
  logic               r_underrun;

  lane_mode_e         w_in_mode;
  logic [CNT_W:0]     w_len_round;
  logic [CNT_W-1:0]   w_new_target;
  logic [C_WB_W-1:0]  w_word_last;
  logic [WORD_W-1:0]  w_shifted;
  logic               w_start;
  logic               w_last;
  logic               w_word_end;
  logic               w_edge;
  logic               w_done;
  logic               w_load;
  logic               w_latch;
  logic               w_ready;
  logic               w_shift_en;
  logic               w_stall_enter;

  assign w_in_mode = lane_mode_e'(mode_in);
  assign w_start   = en && data_valid && (r_bit_len != '0);

  // ceil(bit_len / L) computed as (bit_len + L - 1) >> log2(L).
  assign w_len_round  = {1'b0, r_bit_len} + (CNT_W+1)'(lane_count(w_in_mode) - 3'd1);
  assign w_new_target = CNT_W'(w_len_round >> lane_shift(w_in_mode));

  always_comb begin
    case (r_mode)
      LANE_DUAL: w_word_last = C_WB_W'(WORD_W/2 - 1);
      LANE_QUAD: w_word_last = C_WB_W'(WORD_W/4 - 1);
      default:   w_word_last = C_WB_W'(WORD_W - 1);
    endcase
  end

  assign w_shifted  = r_lsb ? (r_shift >> lane_count(r_mode)) : (r_shift << lane_count(r_mode));
  assign w_last     = (r_beat == (r_target - CNT_W'(1)));
  assign w_word_end = (r_wbeat == w_word_last);
  assign w_edge     = (r_state == ST_TRANSMIT) && tx_edge;
  assign w_done     = w_edge && w_last;

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_latch       = 1'b0;
    w_ready       = 1'b0;
    w_shift_en    = 1'b0;
    w_stall_enter = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_ready     = 1'b1;
          w_load      = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = ST_TRANSMIT;
        end
      end
      ST_TRANSMIT: begin
        if (tx_edge) begin
          // End of transfer wins over a coincident word boundary.
          if (w_last) begin
            if (w_start) begin
              w_ready = 1'b1;
              w_load  = 1'b1;
              w_latch = 1'b1;
            end else begin
              w_shift_en  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else if (w_word_end) begin
            if (data_valid) begin
              w_ready = 1'b1;
              w_load  = 1'b1;
            end else begin
              w_shift_en    = 1'b1;
              w_stall_enter = 1'b1;
              w_state_nxt   = ST_STALL;
            end
          end else begin
            w_shift_en = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (data_valid) begin
          w_ready     = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_TRANSMIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_bit_len  <= CNT_W'(8);
      r_mode     <= LANE_SINGLE;
      r_lsb      <= 1'b0;
      r_target   <= '0;
      r_beat     <= '0;
      r_wbeat    <= '0;
      r_shift    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (counter_in_upd) begin
        r_bit_len <= counter_in;
      end
      if (w_latch) begin
        r_mode     <= w_in_mode;
        r_lsb      <= lsb_first_in;
        r_target   <= w_new_target;
        r_underrun <= 1'b0;
      end else if (w_stall_enter) begin
        r_underrun <= 1'b1;
      end
      if (w_latch || w_done) begin
        r_beat <= '0;
      end else if (w_edge) begin
        r_beat <= r_beat + CNT_W'(1);
      end
      if (w_load || (w_edge && w_word_end)) begin
        r_wbeat <= '0;
      end else if (w_edge) begin
        r_wbeat <= r_wbeat + C_WB_W'(1);
      end
      if (w_load) begin
        r_shift <= data;
      end else if (w_shift_en) begin
        r_shift <= w_shifted;
      end
    end
  end

  // Strobes are gated by rstn so an in-flight transfer is silenced during reset.
  assign data_ready = rstn && w_ready;
  assign tx_done    = rstn && w_done;
  assign clk_en_o   = rstn && (r_state == ST_TRANSMIT) && !(w_done && !w_start);
  assign underrun   = r_underrun;

  spi_tx_lane_mux #(
    .WORD_W (WORD_W)
  ) u_lane_mux (
    .shift_reg (r_shift),
    .mode      (r_mode),
    .lsb_first (r_lsb),
    .active    (rstn && (r_state != ST_IDLE)),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe)
  );

endmodule

`default_nettype wire

// File: tb/tb_spi_master_tx_ml.sv
// ============================================================================
// Module : tb_spi_master_tx_ml
// Brief  : Scoreboard bench for spi_master_tx_ml (single/dual/quad, stall, reset).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_tx_ml;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        tx_edge;
  logic [1:0]  mode_in;
  logic        lsb_first_in;
  logic [15:0] counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  sdo;
  logic [3:0]  sdo_oe;
  logic        tx_done;
  logic        clk_en_o;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  logic [3:0] sdo_q[$];
  logic [3:0] exp;

  spi_master_tx_ml #(.WORD_W(32), .CNT_W(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .tx_edge        (tx_edge),
    .mode_in        (mode_in),
    .lsb_first_in   (lsb_first_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .sdo            (sdo),
    .sdo_oe         (sdo_oe),
    .tx_done        (tx_done),
    .clk_en_o       (clk_en_o),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference lane values for beat k of word w.
  function automatic logic [3:0] ref_sdo(input logic [31:0] w, input int lanes,
                                         input bit lsb, input int k);
    logic [31:0] s;
    logic [3:0]  r;
    r = 4'b0000;
    s = lsb ? (w >> (k * lanes)) : (w << (k * lanes));
    for (int j = 0; j < lanes; j++) r[j] = lsb ? s[j] : s[32 - lanes + j];
    return r;
  endfunction

  task automatic load_len(input logic [15:0] v);
    @(negedge clk);
    counter_in     = v;
    counter_in_upd = 1'b1;
    @(posedge clk); #1;
    counter_in_upd = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; en = 1'b0; tx_edge = 1'b0; mode_in = 2'b00; lsb_first_in = 1'b0;
    counter_in = '0; counter_in_upd = 1'b0; data = '0; data_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sdo, sdo_oe, data_ready, tx_done, clk_en_o, underrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000",
               {sdo, sdo_oe, data_ready, tx_done, clk_en_o, underrun});
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({sdo_oe, clk_en_o, underrun} !== 6'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 000000", {sdo_oe, clk_en_o, underrun});
    end
  endtask

  task automatic test_single_msb;
    bit seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    mode_in = 2'b00; lsb_first_in = 1'b0;
    load_len(16'd8);
    // tx_edge in IDLE must not disturb anything
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== 1'b0 || sdo_oe !== 4'b0000) begin
        errors++;
        $display("FAIL idle_edge_ignored: got done=%b oe=%b expected done=0 oe=0000", tx_done, sdo_oe);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
    for (int i = 0; i < 8; i++) sdo_q.push_back({3'b000, seq[i]});
    @(negedge clk);
    en = 1'b1; data = 32'hA500_0000; data_valid = 1'b1; #1;
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_start_ready: got %b expected 1", data_ready);
    end
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || sdo_oe !== 4'b0001 || clk_en_o !== 1'b1) begin
        errors++;
        $display("FAIL single_beat%0d: got sdo=%b oe=%b clk_en=%b expected sdo=%b oe=0001 clk_en=1",
                 i, sdo, sdo_oe, clk_en_o, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 7) || (i == 7 && clk_en_o !== 1'b0)) begin
        errors++;
        $display("FAIL single_done%0d: got done=%b clk_en=%b expected done=%b", i, tx_done, clk_en_o, i == 7);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (sdo_oe !== 4'b0000 || clk_en_o !== 1'b0) begin
      errors++;
      $display("FAIL single_back_idle: got oe=%b clk_en=%b expected 0000 0", sdo_oe, clk_en_o);
    end
  endtask

  task automatic test_quad;
    mode_in = 2'b10; lsb_first_in = 1'b0;
    load_len(16'd32);
    for (int i = 0; i < 8; i++) sdo_q.push_back(4'(i + 1));
    @(negedge clk);
    data = 32'h1234_5678; data_valid = 1'b1;
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || sdo_oe !== 4'b1111) begin
        errors++;
        $display("FAIL quad_beat%0d: got sdo=%h oe=%b expected sdo=%h oe=1111", i, sdo, sdo_oe, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 7)) begin
        errors++;
        $display("FAIL quad_done%0d: got %b expected %b", i, tx_done, i == 7);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
  endtask

  task automatic test_dual_lsb;
    mode_in = 2'b01; lsb_first_in = 1'b1;
    load_len(16'd6);
    sdo_q.push_back(4'b0001); sdo_q.push_back(4'b0011); sdo_q.push_back(4'b0010);
    @(negedge clk);
    data = 32'h0000_002D; data_valid = 1'b1;
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || sdo_oe !== 4'b0011) begin
        errors++;
        $display("FAIL dual_beat%0d: got sdo=%b oe=%b expected sdo=%b oe=0011", i, sdo, sdo_oe, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 2)) begin
        errors++;
        $display("FAIL dual_done%0d: got %b expected %b", i, tx_done, i == 2);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
  endtask

  task automatic test_zero_len;
    mode_in = 2'b00; lsb_first_in = 1'b0;
    load_len(16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_valid = 1'b1; #1;
      checks++;
      if (data_ready !== 1'b0 || sdo_oe !== 4'b0000 || clk_en_o !== 1'b0) begin
        errors++;
        $display("FAIL zero_len_idle: got ready=%b oe=%b clk_en=%b expected 0 0000 0",
                 data_ready, sdo_oe, clk_en_o);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_stall;
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    mode_in = 2'b00; lsb_first_in = 1'b0;
    load_len(16'd64);
    for (int k = 0; k < 32; k++) sdo_q.push_back(ref_sdo(w0, 1, 1'b0, k));
    for (int k = 0; k < 32; k++) sdo_q.push_back(ref_sdo(w1, 1, 1'b0, k));
    @(negedge clk);
    data = w0; data_valid = 1'b1;
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_w0_beat%0d: got sdo=%b done=%b expected sdo=%b done=0", i, sdo, tx_done, exp);
      end
      tx_edge = 1'b1;
      @(posedge clk); #1; tx_edge = 1'b0;
    end
    // tx_edge while stalled must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_edge = (i < 2); #1;
      checks++;
      if (clk_en_o !== 1'b0 || underrun !== 1'b1 || sdo_oe !== 4'b0001 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got clk_en=%b underrun=%b oe=%b done=%b expected 0 1 0001 0",
                 i, clk_en_o, underrun, sdo_oe, tx_done);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
    @(negedge clk);
    data = w1; data_valid = 1'b1; #1;
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume_ready: got %b expected 1", data_ready);
    end
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || clk_en_o !== 1'b1 || underrun !== 1'b1) begin
        errors++;
        $display("FAIL stall_w1_beat%0d: got sdo=%b clk_en=%b underrun=%b expected sdo=%b 1 1",
                 i, sdo, clk_en_o, underrun, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 31)) begin
        errors++;
        $display("FAIL stall_done%0d: got %b expected %b", i, tx_done, i == 31);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    bit seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    mode_in = 2'b00; lsb_first_in = 1'b0;
    load_len(16'd8);
    for (int i = 0; i < 8; i++) sdo_q.push_back({3'b000, seq[i]});
    for (int i = 0; i < 8; i++) sdo_q.push_back(4'(i + 1));
    @(negedge clk);
    data = 32'hA500_0000; data_valid = 1'b1;
    @(posedge clk); #1;
    // Mid-transfer changes: must not affect the transfer already in flight
    data = 32'h1234_5678; mode_in = 2'b10; counter_in = 16'd32; counter_in_upd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || sdo_oe !== 4'b0001 || (i == 0 && underrun !== 1'b0)) begin
        errors++;
        $display("FAIL b2b_first_beat%0d: got sdo=%b oe=%b underrun=%b expected sdo=%b oe=0001",
                 i, sdo, sdo_oe, underrun, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 7) || data_ready !== (i == 7) || clk_en_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_first_done%0d: got done=%b ready=%b clk_en=%b expected %b %b 1",
                 i, tx_done, data_ready, clk_en_o, i == 7, i == 7);
      end
      @(posedge clk); #1; tx_edge = 1'b0; counter_in_upd = 1'b0;
    end
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || sdo_oe !== 4'b1111 || clk_en_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_quad_beat%0d: got sdo=%h oe=%b clk_en=%b expected sdo=%h oe=1111 1",
                 i, sdo, sdo_oe, clk_en_o, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 7)) begin
        errors++;
        $display("FAIL b2b_quad_done%0d: got %b expected %b", i, tx_done, i == 7);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (sdo_oe !== 4'b0000 || clk_en_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got oe=%b clk_en=%b expected 0000 0", sdo_oe, clk_en_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] w;
    bit seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    w = $urandom;
    mode_in = 2'b10; lsb_first_in = 1'b0;
    load_len(16'd32);
    for (int k = 0; k < 3; k++) sdo_q.push_back(ref_sdo(w, 4, 1'b0, k));
    @(negedge clk);
    data = w; data_valid = 1'b1;
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp) begin
        errors++;
        $display("FAIL rstmid_beat%0d: got %h expected %h", i, sdo, exp);
      end
      tx_edge = 1'b1;
      @(posedge clk); #1; tx_edge = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0; tx_edge = 1'b1; #1;
    checks++;
    if ({sdo, sdo_oe, data_ready, tx_done, clk_en_o} !== 11'h000) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h expected 000", {sdo, sdo_oe, data_ready, tx_done, clk_en_o});
    end
    @(posedge clk); #1; rstn = 1'b1; tx_edge = 1'b0;
    @(negedge clk);
    checks++;
    if ({sdo_oe, clk_en_o, underrun, tx_done} !== 7'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got %b expected 0000000", {sdo_oe, clk_en_o, underrun, tx_done});
    end
    // bit_len must be back to 8: an 8-beat single transfer with no reload
    mode_in = 2'b00;
    for (int i = 0; i < 8; i++) sdo_q.push_back({3'b000, seq[i]});
    @(negedge clk);
    data = 32'hA500_0000; data_valid = 1'b1;
    @(posedge clk); #1; data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = sdo_q.pop_front();
      checks++;
      if (sdo !== exp || sdo_oe !== 4'b0001) begin
        errors++;
        $display("FAIL rstmid_len_beat%0d: got sdo=%b oe=%b expected sdo=%b oe=0001", i, sdo, sdo_oe, exp);
      end
      tx_edge = 1'b1; #1;
      checks++;
      if (tx_done !== (i == 7)) begin
        errors++;
        $display("FAIL rstmid_len_done%0d: got %b expected %b", i, tx_done, i == 7);
      end
      @(posedge clk); #1; tx_edge = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_quad();
    test_dual_lsb();
    test_zero_len();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sdo_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sdo_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
